// File: rtl/ps2_paddle_key_ctrl_if.sv
// Scan-byte bus from the PS/2 receiver into the Pong key controller.
interface ps2_paddle_key_ctrl_if;
    logic       key_strobe;
    logic [7:0] key_data;

    modport master (output key_strobe, output key_data);
    modport slave  (input  key_strobe, input  key_data);
endinterface

// File: rtl/ps2_paddle_key_ctrl.sv
// Decodes PS/2 make/break/extended scan sequences into Pong paddle, pause and restart controls.
//  state     | meaning
//  S_IDLE    | no prefix pending, next byte is a plain make code
//  S_EXT     | E0 seen, next code is an extended make
//  S_BRK     | F0 seen, next code is a plain break
//  S_EXT_BRK | E0 F0 seen, next code is an extended break
module ps2_paddle_key_ctrl #(
    parameter int PREFIX_TIMEOUT = 500000,
    parameter int TO_W           = 19
) (
    input  logic                        inclock,
    input  logic                        resetn,
    ps2_paddle_key_ctrl_if.slave        key_bus,
    output logic                        p1_up,
    output logic                        p1_down,
    output logic                        p2_up,
    output logic                        p2_down,
    output logic                        paused,
    output logic                        restart,
    output logic                        proto_err,
    output logic [1:0]                  seq_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0] C_E0 = 8'hE0, C_F0 = 8'hF0;
    localparam logic [7:0] C_W = 8'h1D, C_S = 8'h1B, C_SP = 8'h29, C_ESC = 8'h76;
    localparam logic [7:0] C_UP = 8'h75, C_DN = 8'h72;
    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(PREFIX_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            w_h, s_h, sp_h, esc_h, up_h, dn_h;
    logic            w_d, s_d, sp_d, esc_d, up_d, dn_d;
    logic            paused_d, restart_d, perr_d;
    logic [7:0]      code;

    assign code      = key_bus.key_data;
    assign seq_state = state_q;

    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            w_h       <= 1'b0;
            s_h       <= 1'b0;
            sp_h      <= 1'b0;
            esc_h     <= 1'b0;
            up_h      <= 1'b0;
            dn_h      <= 1'b0;
            paused    <= 1'b0;
            restart   <= 1'b0;
            proto_err <= 1'b0;
            p1_up     <= 1'b0;
            p1_down   <= 1'b0;
            p2_up     <= 1'b0;
            p2_down   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            w_h       <= w_d;
            s_h       <= s_d;
            sp_h      <= sp_d;
            esc_h     <= esc_d;
            up_h      <= up_d;
            dn_h      <= dn_d;
            paused    <= paused_d;
            restart   <= restart_d;
            proto_err <= perr_d;
            // Paddle levels come from the next-flag values so a byte shows up one cycle later.
            p1_up     <= w_d & ~s_d;
            p1_down   <= s_d & ~w_d;
            p2_up     <= up_d & ~dn_d;
            p2_down   <= dn_d & ~up_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        w_d       = w_h;
        s_d       = s_h;
        sp_d      = sp_h;
        esc_d     = esc_h;
        up_d      = up_h;
        dn_d      = dn_h;
        paused_d  = paused;
        restart_d = 1'b0;
        perr_d    = 1'b0;

        if (key_bus.key_strobe) begin
            cnt_d = '0;
            unique case (state_q)
                S_IDLE: begin
                    if (code == C_E0)      state_d = S_EXT;
                    else if (code == C_F0) state_d = S_BRK;
                    else if (code == C_W)  w_d = 1'b1;
                    else if (code == C_S)  s_d = 1'b1;
                    else if (code == C_SP) begin
                        if (!sp_h) paused_d = ~paused;
                        sp_d = 1'b1;
                    end else if (code == C_ESC) begin
                        if (!esc_h) restart_d = 1'b1;
                        esc_d = 1'b1;
                    end
                end
                S_EXT: begin
                    state_d = S_IDLE;
                    if (code == C_F0)      state_d = S_EXT_BRK;
                    else if (code == C_E0) state_d = S_EXT;
                    else if (code == C_UP) up_d = 1'b1;
                    else if (code == C_DN) dn_d = 1'b1;
                end
                S_BRK: begin
                    state_d = S_IDLE;
                    if (code == C_E0)       state_d = S_EXT_BRK;
                    else if (code == C_F0)  state_d = S_BRK;
                    else if (code == C_W)   w_d = 1'b0;
                    else if (code == C_S)   s_d = 1'b0;
                    else if (code == C_SP)  sp_d = 1'b0;
                    else if (code == C_ESC) esc_d = 1'b0;
                end
                S_EXT_BRK: begin
                    state_d = S_IDLE;
                    if (code == C_E0 || code == C_F0) state_d = S_EXT_BRK;
                    else if (code == C_UP)            up_d = 1'b0;
                    else if (code == C_DN)            dn_d = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            // An abandoned prefix is dropped; held keys are kept as they were.
            if (cnt_q == CNT_LAST) begin
                state_d = S_IDLE;
                perr_d  = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + TO_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

endmodule

// File: tb/tb_ps2_paddle_key_ctrl.sv
// Scoreboard bench for ps2_paddle_key_ctrl: a key-table reference model predicts every output cycle.
module tb_ps2_paddle_key_ctrl;

    localparam int TIMEOUT = 16;

    logic       inclock = 1'b0;
    logic       resetn  = 1'b0;
    logic       p1_up, p1_down, p2_up, p2_down, paused, restart, proto_err;
    logic [1:0] seq_state;

    ps2_paddle_key_ctrl_if bus ();

    ps2_paddle_key_ctrl #(.PREFIX_TIMEOUT(TIMEOUT), .TO_W(5)) dut (
        .inclock   (inclock),
        .resetn    (resetn),
        .key_bus   (bus),
        .p1_up     (p1_up),
        .p1_down   (p1_down),
        .p2_up     (p2_up),
        .p2_down   (p2_down),
        .paused    (paused),
        .restart   (restart),
        .proto_err (proto_err),
        .seq_state (seq_state)
    );

    always #5 inclock = ~inclock;

    int checks = 0;
    int passed = 0;
    logic [8:0] exp_q[$];

    // Reference model: pending prefix flags plus a table of held keys indexed by {ext, code}.
    bit m_ext, m_brk, m_paused, m_restart, m_perr;
    int m_idle;
    bit held[512];

    function automatic logic [8:0] dut_vec();
        return {p1_up, p1_down, p2_up, p2_down, paused, restart, proto_err, seq_state};
    endfunction

    function automatic bit tracked(input int k);
        return k == 'h1D || k == 'h1B || k == 'h29 || k == 'h76 || k == 'h175 || k == 'h172;
    endfunction

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_paused = 0; m_restart = 0; m_perr = 0; m_idle = 0;
        for (int i = 0; i < 512; i++) held[i] = 0;
    endtask

    task automatic model_step(input bit s, input logic [7:0] d);
        int k;
        m_restart = 0;
        m_perr    = 0;
        if (s) begin
            m_idle = 0;
            if (d == 8'hE0) m_ext = 1;
            else if (d == 8'hF0) m_brk = 1;
            else begin
                k = (m_ext ? 256 : 0) + int'(d);
                if (tracked(k)) begin
                    if (!m_brk) begin
                        if (!held[k] && k == 'h29) m_paused = !m_paused;
                        if (!held[k] && k == 'h76) m_restart = 1;
                        held[k] = 1;
                    end else begin
                        held[k] = 0;
                    end
                end
                m_ext = 0;
                m_brk = 0;
            end
        end else if (m_ext || m_brk) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                m_ext = 0; m_brk = 0; m_idle = 0; m_perr = 1;
            end
        end
    endtask

    function automatic logic [8:0] model_vec();
        return {held['h1D] & !held['h1B], held['h1B] & !held['h1D],
                held['h175] & !held['h172], held['h172] & !held['h175],
                m_paused, m_restart, m_perr, m_brk, m_ext};
    endfunction

    task automatic drive(input bit s, input logic [7:0] d);
        @(negedge inclock);
        bus.key_strobe = s;
        bus.key_data   = s ? d : 8'($urandom);
        model_step(s, d);
        exp_q.push_back(model_vec());
    endtask

    task automatic seq(input logic [7:0] b[$]);
        foreach (b[i]) drive(1'b1, b[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00);
    endtask

    task automatic check_direct(input string name, input logic [8:0] act, input logic [8:0] expv);
        checks++;
        if (act !== expv) $display("FAIL %s: got %b expected %b", name, act, expv);
        else passed++;
    endtask

    // Monitor: outputs are level signals valid every cycle, so each cycle pops one prediction.
    initial begin
        logic [8:0] e;
        forever begin
            @(posedge inclock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (dut_vec() !== e)
                    $display("FAIL out_vec t=%0t: got %b expected %b (p1u p1d p2u p2d pau rst err seq)",
                             $time, dut_vec(), e);
                else
                    passed++;
            end
        end
    end

    initial begin
        logic [7:0] codes[10];
        codes = '{8'h1D, 8'h1B, 8'h29, 8'h76, 8'h75, 8'h72, 8'hE0, 8'hF0, 8'h1D, 8'h5A};
        bus.key_strobe = 1'b0;
        bus.key_data   = 8'h00;
        model_reset();
        #2;
        check_direct("reset_outputs", dut_vec(), 9'b0);
        repeat (3) @(negedge inclock);
        resetn = 1'b1;

        // W held with typematic repeats, then released; W+S cancel
        seq('{8'h1D}); idle(1); seq('{8'h1D, 8'h1D}); idle(2);
        seq('{8'hF0, 8'h1D}); idle(1);
        seq('{8'h1D, 8'h1B}); idle(2); seq('{8'hF0, 8'h1B, 8'hF0, 8'h1D});

        // P2 arrows, extended break, and E0 1D not touching W
        seq('{8'hE0, 8'h75}); idle(1); seq('{8'hE0, 8'h72}); idle(1);
        seq('{8'hE0, 8'hF0, 8'h75}); idle(1);
        seq('{8'hE0, 8'h1D}); idle(1); seq('{8'hE0, 8'hF0, 8'h72});

        // Pause toggle with repeats, restart pulse filtered
        seq('{8'h29, 8'h29, 8'h29, 8'hF0, 8'h29, 8'h29}); idle(2);
        seq('{8'h76, 8'h76}); idle(2); seq('{8'hF0, 8'h76, 8'hF0, 8'h29});

        // Prefix timeout, ignored following 75, strobe on the expiry cycle
        seq('{8'hE0}); idle(TIMEOUT + 1); seq('{8'h75}); idle(1);
        seq('{8'hE0}); idle(TIMEOUT - 1); seq('{8'h75}); idle(2);
        seq('{8'hF0}); idle(TIMEOUT - 2); seq('{8'hE0}); idle(TIMEOUT + 2);
        seq('{8'hE0, 8'hF0, 8'h75});

        // Back-to-back release of W
        seq('{8'h1D}); seq('{8'hF0, 8'h1D}); idle(1);

        // Asynchronous reset in the middle of an extended prefix
        seq('{8'h1D, 8'hF0, 8'h29, 8'h29, 8'hE0}); idle(1);
        @(posedge inclock);
        #3;
        resetn = 1'b0;
        #1;
        check_direct("async_reset_mid_ext", dut_vec(), 9'b0);
        model_reset();
        repeat (3) @(negedge inclock);
        #1 check_direct("held_in_reset", dut_vec(), 9'b0);
        resetn = 1'b1;
        idle(2);
        seq('{8'h75}); idle(1);

        // Randomized byte stream with occasional long gaps to hit timeouts
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 39) == 0) idle($urandom_range(TIMEOUT - 3, TIMEOUT + 3));
            else if ($urandom_range(0, 1) == 1) drive(1'b1, codes[$urandom_range(0, 9)]);
            else drive(1'b0, 8'h00);
        end
        idle(4);
        @(posedge inclock);
        #3;
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
